// File: rtl/scale_pkg.sv
// Shared definitions for the scale FIFO and its drain-side row reader:
// default geometry, derived plane/vector widths and the reader state encoding.
package scale_pkg;

   localparam int DEF_MAT_SIZE  = 16;
   localparam int DEF_FP_MANT_W = 23;
   localparam int DEF_FP_EXP_W  = 8;
   localparam int DEF_CNT_W     = 16;

   localparam int IDX_W      = $clog2(DEF_MAT_SIZE);
   localparam int MANT_VEC_W = DEF_FP_MANT_W * DEF_MAT_SIZE;
   localparam int EXP_VEC_W  = DEF_FP_EXP_W * DEF_MAT_SIZE;
   localparam int MANT_MAT_W = MANT_VEC_W * DEF_MAT_SIZE;
   localparam int EXP_MAT_W  = EXP_VEC_W * DEF_MAT_SIZE;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } scale_state_e;

endpackage

// File: rtl/scale_row_sel.sv
// Combinational lane selector: picks row k (trans=0) or column k (trans=1)
// of a packed MAT_SIZE x MAT_SIZE element plane as one packed vector.
module scale_row_sel
   import scale_pkg::*;
#(
   parameter  int MAT_SIZE = DEF_MAT_SIZE,
   parameter  int EL_W     = DEF_FP_MANT_W,
   localparam int SEL_W    = $clog2(MAT_SIZE)
) (
   input  logic [EL_W*MAT_SIZE*MAT_SIZE-1:0] mat_buf,
   input  logic [SEL_W-1:0]                  k,
   input  logic                              trans,
   output logic [EL_W*MAT_SIZE-1:0]          vec
);

   // Lane j takes element (k,j) in row order or (j,k) in column order.
   always_comb begin
      vec = '0;
      for (int j = 0; j < MAT_SIZE; j++) begin
         if (trans) begin
            vec[j*EL_W +: EL_W] = mat_buf[(j*MAT_SIZE + int'(k))*EL_W +: EL_W];
         end else begin
            vec[j*EL_W +: EL_W] = mat_buf[(int'(k)*MAT_SIZE + j)*EL_W +: EL_W];
         end
      end
   end

endmodule

// File: rtl/scale_row_reader.sv
// Pops one scale matrix from the show-ahead FIFO port and streams it out as
// MAT_SIZE row or column vectors; a last-row accept may pop the next matrix.
module scale_row_reader
   import scale_pkg::*;
#(
   parameter  int MAT_SIZE  = DEF_MAT_SIZE,
   parameter  int FP_MANT_W = DEF_FP_MANT_W,
   parameter  int FP_EXP_W  = DEF_FP_EXP_W,
   parameter  int CNT_W     = DEF_CNT_W,
   localparam int RIDX_W    = $clog2(MAT_SIZE),
   localparam int MVEC_W    = FP_MANT_W * MAT_SIZE,
   localparam int EVEC_W    = FP_EXP_W * MAT_SIZE,
   localparam int MMAT_W    = MVEC_W * MAT_SIZE,
   localparam int EMAT_W    = EVEC_W * MAT_SIZE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_valid_i,
   output logic              fifo_ready_o,
   input  logic [MMAT_W-1:0] mant_mat_i,
   input  logic [EMAT_W-1:0] exp_mat_i,
   input  logic              trans_i,
   output logic              row_valid_o,
   input  logic              row_ready_i,
   output logic [MVEC_W-1:0] row_mant_o,
   output logic [EVEC_W-1:0] row_exp_o,
   output logic [RIDX_W-1:0] row_idx_o,
   output logic              row_last_o,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              mat_done_o,
   output logic [CNT_W-1:0]  mat_cnt_o
);

   scale_state_e      state_r, state_nxt_s;
   logic [RIDX_W-1:0] row_idx_r, idx_nxt_s;
   logic [CNT_W-1:0]  mat_cnt_r, cnt_nxt_s;
   logic              done_r, done_nxt_s;
   logic              trans_r;
   logic [MMAT_W-1:0] mant_buf_r;
   logic [EMAT_W-1:0] exp_buf_r;
   logic              accept_s, last_s, pop_s;

   assign row_valid_o = (state_r == ST_STREAM);
   assign accept_s    = row_valid_o & row_ready_i;
   assign last_s      = (row_idx_r == RIDX_W'(MAT_SIZE - 1));
   // Ready never looks at fifo_valid_i, so no valid-to-output comb path exists.
   assign fifo_ready_o = ~rst & ~flush_i & ((state_r == ST_IDLE) | (accept_s & last_s));
   assign pop_s        = fifo_valid_i & fifo_ready_o;

   assign row_last_o = row_valid_o & last_s;
   assign row_idx_o  = row_idx_r;
   assign busy_o     = row_valid_o;
   assign mat_done_o = done_r;
   assign mat_cnt_o  = mat_cnt_r;

   // Next-state, row index, completion counter and done pulse.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = row_idx_r;
      cnt_nxt_s   = mat_cnt_r;
      done_nxt_s  = 1'b0;
      if (flush_i) begin
         state_nxt_s = ST_IDLE;
         idx_nxt_s   = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  state_nxt_s = ST_STREAM;
                  idx_nxt_s   = '0;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_STREAM: begin
               if (accept_s) begin
                  if (last_s) begin
                     done_nxt_s  = 1'b1;
                     cnt_nxt_s   = mat_cnt_r + CNT_W'(1'b1);
                     idx_nxt_s   = '0;
                     state_nxt_s = pop_s ? ST_STREAM : ST_IDLE;
                  end else begin
                     idx_nxt_s = row_idx_r + RIDX_W'(1'b1);
                  end
               end else begin
                  idx_nxt_s = row_idx_r;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               idx_nxt_s   = '0;
            end
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         row_idx_r <= '0;
         mat_cnt_r <= '0;
         done_r    <= 1'b0;
         trans_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         row_idx_r <= idx_nxt_s;
         mat_cnt_r <= cnt_nxt_s;
         done_r    <= done_nxt_s;
         trans_r   <= pop_s ? trans_i : trans_r;
      end
   end

   // Matrix buffer: written only on a pop, so vectors hold steady while stalled.
   always_ff @(posedge clk) begin
      if (pop_s) begin
         mant_buf_r <= mant_mat_i;
         exp_buf_r  <= exp_mat_i;
      end else begin
         mant_buf_r <= mant_buf_r;
         exp_buf_r  <= exp_buf_r;
      end
   end

   scale_row_sel #(
      .MAT_SIZE (MAT_SIZE),
      .EL_W     (FP_MANT_W)
   ) u_mant_sel (
      .mat_buf (mant_buf_r),
      .k       (row_idx_r),
      .trans   (trans_r),
      .vec     (row_mant_o)
   );

   scale_row_sel #(
      .MAT_SIZE (MAT_SIZE),
      .EL_W     (FP_EXP_W)
   ) u_exp_sel (
      .mat_buf (exp_buf_r),
      .k       (row_idx_r),
      .trans   (trans_r),
      .vec     (row_exp_o)
   );

endmodule

// File: tb/tb_scale_row_reader.sv
// Scoreboard bench for scale_row_reader: a FIFO model feeds matrices, popped
// matrices push expected vectors that are compared as the DUT hands them out.
module tb_scale_row_reader;

   localparam int MS   = 4;
   localparam int MW   = 23;
   localparam int EW   = 8;
   localparam int CW   = 4;
   localparam int IW   = $clog2(MS);
   localparam int MV_W = MW * MS;
   localparam int EV_W = EW * MS;
   localparam int MM_W = MV_W * MS;
   localparam int EM_W = EV_W * MS;

   typedef struct {
      logic [MM_W-1:0] mant;
      logic [EM_W-1:0] exp;
      logic            trans;
   } mat_t;

   typedef struct {
      logic [MV_W-1:0] mant;
      logic [EV_W-1:0] exp;
      int              idx;
   } vec_t;

   logic            clk;
   logic            rst;
   logic            fifo_valid_i;
   logic            fifo_ready_o;
   logic [MM_W-1:0] mant_mat_i;
   logic [EM_W-1:0] exp_mat_i;
   logic            trans_i;
   logic            row_valid_o;
   logic            row_ready_i;
   logic [MV_W-1:0] row_mant_o;
   logic [EV_W-1:0] row_exp_o;
   logic [IW-1:0]   row_idx_o;
   logic            row_last_o;
   logic            flush_i;
   logic            busy_o;
   logic            mat_done_o;
   logic [CW-1:0]   mat_cnt_o;

   mat_t fq[$];
   vec_t sb[$];

   int n_checks = 0;
   int n_err    = 0;
   int cnt_exp  = 0;
   bit done_exp = 1'b0;
   bit hold_v   = 1'b0;
   logic [MV_W-1:0] hold_mant;
   logic [EV_W-1:0] hold_exp;
   logic [IW-1:0]   hold_idx;
   int run_len = 0;
   int max_run = 0;

   scale_row_reader #(
      .MAT_SIZE  (MS),
      .FP_MANT_W (MW),
      .FP_EXP_W  (EW),
      .CNT_W     (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_valid_i (fifo_valid_i),
      .fifo_ready_o (fifo_ready_o),
      .mant_mat_i   (mant_mat_i),
      .exp_mat_i    (exp_mat_i),
      .trans_i      (trans_i),
      .row_valid_o  (row_valid_o),
      .row_ready_i  (row_ready_i),
      .row_mant_o   (row_mant_o),
      .row_exp_o    (row_exp_o),
      .row_idx_o    (row_idx_o),
      .row_last_o   (row_last_o),
      .flush_i      (flush_i),
      .busy_o       (busy_o),
      .mat_done_o   (mat_done_o),
      .mat_cnt_o    (mat_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic drive_fifo();
      if (fq.size() != 0) begin
         fifo_valid_i = 1'b1;
         mant_mat_i   = fq[0].mant;
         exp_mat_i    = fq[0].exp;
         trans_i      = fq[0].trans;
      end else begin
         fifo_valid_i = 1'b0;
      end
   endtask

   // Element (r,c) of matrix m: mant = 256m + 16r + c, exp = r + c + m.
   task automatic push_mat(input int m, input bit tr);
      mat_t x;
      for (int r = 0; r < MS; r++) begin
         for (int c = 0; c < MS; c++) begin
            x.mant[(r*MS+c)*MW +: MW] = MW'(256*m + 16*r + c);
            x.exp[(r*MS+c)*EW +: EW]  = EW'(r + c + m);
         end
      end
      x.trans = tr;
      fq.push_back(x);
      drive_fifo();
   endtask

   task automatic expect_vectors(input mat_t x);
      vec_t v;
      int r, c;
      for (int k = 0; k < MS; k++) begin
         v.idx = k;
         for (int j = 0; j < MS; j++) begin
            r = x.trans ? j : k;
            c = x.trans ? k : j;
            v.mant[j*MW +: MW] = x.mant[(r*MS+c)*MW +: MW];
            v.exp[j*EW +: EW]  = x.exp[(r*MS+c)*EW +: EW];
         end
         sb.push_back(v);
      end
   endtask

   task automatic monitor();
      bit   busy_m, acc, last_acc, ready_m;
      vec_t v;
      mat_t x;
      busy_m   = (sb.size() != 0);
      acc      = busy_m && row_ready_i && !rst && !flush_i;
      last_acc = acc && (sb[0].idx == MS - 1);
      ready_m  = !rst && !flush_i && (!busy_m || last_acc);
      check("mat_done", mat_done_o, done_exp);
      check("mat_cnt", mat_cnt_o, cnt_exp);
      check("row_valid", row_valid_o, busy_m);
      check("busy", busy_o, busy_m);
      check("fifo_ready", fifo_ready_o, ready_m);
      if (busy_m) check("row_last", row_last_o, sb[0].idx == MS - 1);
      else        check("row_last_idle", row_last_o, 1'b0);
      if (hold_v && busy_m) begin
         check("stall_mant", row_mant_o, hold_mant);
         check("stall_exp", row_exp_o, hold_exp);
         check("stall_idx", row_idx_o, hold_idx);
      end
      hold_v    = busy_m && !row_ready_i && !rst && !flush_i;
      hold_mant = row_mant_o;
      hold_exp  = row_exp_o;
      hold_idx  = row_idx_o;
      run_len   = row_valid_o ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      done_exp = 1'b0;
      if (rst) begin
         sb.delete();
         cnt_exp = 0;
      end else if (flush_i) begin
         sb.delete();
      end else if (acc) begin
         v = sb.pop_front();
         check("vec_mant", row_mant_o, v.mant);
         check("vec_exp", row_exp_o, v.exp);
         check("vec_idx", row_idx_o, 128'(v.idx));
         if (v.idx == MS - 1) begin
            done_exp = 1'b1;
            cnt_exp  = (cnt_exp + 1) % (1 << CW);
         end
      end
      if (fifo_valid_i && ready_m) begin
         x = fq.pop_front();
         expect_vectors(x);
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      drive_fifo();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      flush_i      = 1'b0;
      row_ready_i  = 1'b0;
      fifo_valid_i = 1'b0;
      mant_mat_i   = '0;
      exp_mat_i    = '0;
      trans_i      = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      check("rst_idx", row_idx_o, 0);
      check("rst_last", row_last_o, 0);

      // single matrix, row order, then column order
      row_ready_i = 1'b1;
      push_mat(0, 1'b0);
      repeat (8) step();
      push_mat(1, 1'b1);
      repeat (8) step();

      // two matrices back to back
      max_run = 0;
      push_mat(2, 1'b0);
      push_mat(3, 1'b0);
      repeat (12) step();
      check("b2b_run", max_run, 8);
      check("b2b_cnt", mat_cnt_o, 4);

      // alternating downstream stall
      push_mat(4, 1'b1);
      for (int i = 0; i < 14; i++) begin
         row_ready_i = (i % 2 == 0);
         step();
      end
      row_ready_i = 1'b1;
      repeat (6) step();

      // flush at row 2
      push_mat(5, 1'b0);
      for (int t = 0; t < 20 && row_idx_o != 2'd2; t++) step();
      check("flush_reach", row_idx_o, 2);
      row_ready_i = 1'b0;
      flush_i     = 1'b1;
      step();
      flush_i     = 1'b0;
      row_ready_i = 1'b1;
      check("flush_valid", row_valid_o, 0);
      repeat (4) step();

      // reset mid-stream
      push_mat(6, 1'b0);
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_idx", row_idx_o, 0);
      check("rst_mid_cnt", mat_cnt_o, 0);
      check("rst_mid_valid", row_valid_o, 0);
      repeat (2) step();

      // 2^CW matrices wrap the counter
      for (int m = 0; m < (1 << CW); m++) push_mat(10 + m, m[0]);
      repeat ((1 << CW) * MS + 6) step();
      check("cnt_wrap", mat_cnt_o, 0);
      check("sb_drain", sb.size(), 0);
      check("fifo_drain", fq.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
